// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS multi-cycle control sequencer.
// Holds the microstate numbering (kept stable so microstate-indexed tables
// remain valid), opcode/funct encodings and the ordered decode table.
package mips_ctrl_pkg;

  // Microstate codes
  localparam logic [4:0] S_IDLE        = 5'd0;
  localparam logic [4:0] S_FETCH_REQ   = 5'd1;
  localparam logic [4:0] S_FETCH_WAIT  = 5'd2;
  localparam logic [4:0] S_FETCH_LATCH = 5'd3;
  localparam logic [4:0] S_DECODE      = 5'd4;
  localparam logic [4:0] S_ALU_ADDU    = 5'd6;
  localparam logic [4:0] S_ST_REQ      = 5'd7;
  localparam logic [4:0] S_ST_WAIT     = 5'd8;
  localparam logic [4:0] S_BR_EVAL     = 5'd11;
  localparam logic [4:0] S_BR_TAKE     = 5'd12;
  localparam logic [4:0] S_LD_REQ      = 5'd13;
  localparam logic [4:0] S_LD_WAIT     = 5'd14;
  localparam logic [4:0] S_LD_WB       = 5'd15;
  localparam logic [4:0] S_ALU_SUBU    = 5'd17;
  localparam logic [4:0] S_ALU_ADDIU   = 5'd18;
  localparam logic [4:0] S_ALU_SLTU    = 5'd19;
  localparam logic [4:0] S_ALU_SLTIU   = 5'd20;
  localparam logic [4:0] S_ALU_CLO     = 5'd21;
  localparam logic [4:0] S_ALU_CLZ     = 5'd22;
  localparam logic [4:0] S_ALU_AND     = 5'd23;
  localparam logic [4:0] S_TRAP        = 5'd24;
  localparam logic [4:0] S_ERROR       = 5'd31;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  // Function codes (ir[5:0])
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_CLZ  = 6'h20;
  localparam logic [5:0] FN_CLO  = 6'h21;

  typedef struct packed {
    logic [5:0] opcode;
    logic       chk_funct;  // funct field participates in the match
    logic [5:0] funct;
    logic [4:0] code;
  } decode_entry_t;

  // Entry 0 has the highest priority when patterns overlap.
  localparam int NumDecode = 11;
  localparam decode_entry_t DECODE_ORDER [NumDecode] = '{
    '{OP_SPECIAL,  1'b1, FN_ADDU, S_ALU_ADDU},
    '{OP_SPECIAL,  1'b1, FN_SUBU, S_ALU_SUBU},
    '{OP_ADDIU,    1'b0, 6'h00,   S_ALU_ADDIU},
    '{OP_SPECIAL,  1'b1, FN_SLTU, S_ALU_SLTU},
    '{OP_SLTIU,    1'b0, 6'h00,   S_ALU_SLTIU},
    '{OP_SPECIAL2, 1'b1, FN_CLO,  S_ALU_CLO},
    '{OP_SPECIAL2, 1'b1, FN_CLZ,  S_ALU_CLZ},
    '{OP_SPECIAL,  1'b1, FN_AND,  S_ALU_AND},
    '{OP_SW,       1'b0, 6'h00,   S_ST_REQ},
    '{OP_BEQ,      1'b0, 6'h00,   S_BR_EVAL},
    '{OP_LW,       1'b0, 6'h00,   S_LD_REQ}
  };

endpackage

// File: rtl/instr_state_decoder.sv
// Combinational instruction -> first-microstate map.
// Ports:
//   ir   - instruction register contents
//   code - microstate to enter after DECODE; 0 for an unknown encoding
module instr_state_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 7,
  parameter int unsigned IR_W    = 32
) (
  input  logic [IR_W-1:0]    ir,
  output logic [STATE_W-1:0] code
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign opcode         = ir[IR_W-1 -: 6];
  assign funct          = ir[5:0];
  assign unused_ir_bits = ^ir[IR_W-7:6];

  // Walk the table backwards so the lowest-index match is written last and wins.
  always_comb begin
    code = '0;
    for (int i = NumDecode - 1; i >= 0; i--) begin
      if (opcode == DECODE_ORDER[i].opcode &&
          (!DECODE_ORDER[i].chk_funct || funct == DECODE_ORDER[i].funct)) begin
        code = STATE_W'(DECODE_ORDER[i].code);
      end
    end
  end

endmodule

// File: rtl/mips_control_sequencer.sv
// Multi-cycle MIPS control sequencer: fetch / decode / execute / memory
// microstates with a bounded MOC wait and a sticky illegal-opcode flag.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   ir, moc, cond    - instruction, memory-complete handshake, branch condition
//   state            - current microstate code
//   mem_en, mem_rw   - memory request and direction (1 = read)
//   ir_ld, pc_ld     - IR / PC load strobes
//   reg_wr           - register-file write enable
//   illegal          - sticky unknown-opcode flag
//   timeout_err      - high while in ERROR
module mips_control_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W     = 7,
  parameter int unsigned IR_W        = 32,
  parameter int unsigned MOC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IR_W-1:0]    ir,
  input  logic               moc,
  input  logic               cond,
  output logic [STATE_W-1:0] state,
  output logic               mem_en,
  output logic               mem_rw,
  output logic               ir_ld,
  output logic               pc_ld,
  output logic               reg_wr,
  output logic               illegal,
  output logic               timeout_err
);

  localparam int unsigned CntW = (MOC_TIMEOUT > 0) ? $clog2(MOC_TIMEOUT + 1) : 1;
  // Last count at which a missing moc still leaves one more chance; hitting it
  // without moc means MOC_TIMEOUT wait cycles have elapsed.
  localparam logic [CntW-1:0] CntLast = (MOC_TIMEOUT > 0) ? CntW'(MOC_TIMEOUT - 1) : '0;

  logic [STATE_W-1:0] state_q, state_d, dec_code;
  logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;
  logic               in_wait, timeout_hit;

  instr_state_decoder #(
    .STATE_W (STATE_W),
    .IR_W    (IR_W)
  ) u_decoder (
    .ir   (ir),
    .code (dec_code)
  );

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    in_wait     = state_q inside {STATE_W'(S_FETCH_WAIT), STATE_W'(S_ST_WAIT),
                                  STATE_W'(S_LD_WAIT)};
    timeout_hit = (MOC_TIMEOUT != 0) && in_wait && !moc && (wait_cnt_q == CntLast);

    case (state_q)
      STATE_W'(S_IDLE):        state_d = STATE_W'(S_FETCH_REQ);
      STATE_W'(S_FETCH_REQ):   state_d = STATE_W'(S_FETCH_WAIT);
      STATE_W'(S_FETCH_WAIT): begin
        if (moc)              state_d = STATE_W'(S_FETCH_LATCH);
        else if (timeout_hit) state_d = STATE_W'(S_ERROR);
      end
      STATE_W'(S_FETCH_LATCH): state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE):      state_d = (dec_code == '0) ? STATE_W'(S_TRAP) : dec_code;
      STATE_W'(S_ALU_ADDU), STATE_W'(S_ALU_SUBU), STATE_W'(S_ALU_ADDIU),
      STATE_W'(S_ALU_SLTU), STATE_W'(S_ALU_SLTIU), STATE_W'(S_ALU_CLO),
      STATE_W'(S_ALU_CLZ), STATE_W'(S_ALU_AND):
                               state_d = STATE_W'(S_FETCH_REQ);
      STATE_W'(S_ST_REQ):      state_d = STATE_W'(S_ST_WAIT);
      STATE_W'(S_ST_WAIT): begin
        if (moc)              state_d = STATE_W'(S_FETCH_REQ);
        else if (timeout_hit) state_d = STATE_W'(S_ERROR);
      end
      STATE_W'(S_BR_EVAL):     state_d = STATE_W'(S_BR_TAKE);
      STATE_W'(S_BR_TAKE):     state_d = STATE_W'(S_FETCH_REQ);
      STATE_W'(S_LD_REQ):      state_d = STATE_W'(S_LD_WAIT);
      STATE_W'(S_LD_WAIT): begin
        if (moc)              state_d = STATE_W'(S_LD_WB);
        else if (timeout_hit) state_d = STATE_W'(S_ERROR);
      end
      STATE_W'(S_LD_WB):       state_d = STATE_W'(S_FETCH_REQ);
      STATE_W'(S_TRAP):        state_d = STATE_W'(S_FETCH_REQ);
      STATE_W'(S_ERROR):       state_d = STATE_W'(S_ERROR);
      default:                 state_d = STATE_W'(S_ERROR);
    endcase

    // Leaving a wait state zeroes the count, so every entry starts from 0.
    wait_cnt_d = '0;
    if (MOC_TIMEOUT != 0 && in_wait && !moc) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  // cond is captured on the edge into BR_TAKE to keep pc_ld a registered signal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= '0;
      wait_cnt_q  <= '0;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      ir_ld       <= 1'b0;
      pc_ld       <= 1'b0;
      reg_wr      <= 1'b0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_en      <= state_d inside {STATE_W'(S_FETCH_REQ), STATE_W'(S_FETCH_WAIT),
                                     STATE_W'(S_ST_REQ), STATE_W'(S_ST_WAIT),
                                     STATE_W'(S_LD_REQ), STATE_W'(S_LD_WAIT)};
      mem_rw      <= state_d inside {STATE_W'(S_FETCH_REQ), STATE_W'(S_FETCH_WAIT),
                                     STATE_W'(S_LD_REQ), STATE_W'(S_LD_WAIT)};
      ir_ld       <= (state_d == STATE_W'(S_FETCH_LATCH));
      pc_ld       <= (state_d == STATE_W'(S_FETCH_LATCH)) ||
                     ((state_d == STATE_W'(S_BR_TAKE)) && cond);
      reg_wr      <= state_d inside {STATE_W'(S_ALU_ADDU), STATE_W'(S_ALU_SUBU),
                                     STATE_W'(S_ALU_ADDIU), STATE_W'(S_ALU_SLTU),
                                     STATE_W'(S_ALU_SLTIU), STATE_W'(S_ALU_CLO),
                                     STATE_W'(S_ALU_CLZ), STATE_W'(S_ALU_AND),
                                     STATE_W'(S_LD_WB)};
      illegal     <= illegal | (state_d == STATE_W'(S_TRAP));
      timeout_err <= (state_d == STATE_W'(S_ERROR));
    end
  end

endmodule

// File: tb/tb_mips_control_sequencer.sv
// Directed bench for mips_control_sequencer (MOC_TIMEOUT = 4).
// Output vector packing: {mem_en, mem_rw, ir_ld, pc_ld, reg_wr, illegal, timeout_err}
module tb_mips_control_sequencer;

  localparam int STATE_W = 7;
  localparam int IR_W    = 32;

  localparam logic [31:0] IR_ADDU = 32'h0085_1021;
  localparam logic [31:0] IR_LW   = 32'h8C85_0004;
  localparam logic [31:0] IR_SW   = 32'hAC85_0008;
  localparam logic [31:0] IR_BEQ  = 32'h1085_0003;
  localparam logic [31:0] IR_BAD  = 32'hFC00_0000;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [IR_W-1:0]    ir;
  logic               moc, cond;
  logic [STATE_W-1:0] state;
  logic               mem_en, mem_rw, ir_ld, pc_ld, reg_wr, illegal, timeout_err;
  logic [6:0]         outs;

  int checks = 0;
  int passed = 0;

  assign outs = {mem_en, mem_rw, ir_ld, pc_ld, reg_wr, illegal, timeout_err};

  always #5 clk = ~clk;

  mips_control_sequencer #(
    .STATE_W     (STATE_W),
    .IR_W        (IR_W),
    .MOC_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ir          (ir),
    .moc         (moc),
    .cond        (cond),
    .state       (state),
    .mem_en      (mem_en),
    .mem_rw      (mem_rw),
    .ir_ld       (ir_ld),
    .pc_ld       (pc_ld),
    .reg_wr      (reg_wr),
    .illegal     (illegal),
    .timeout_err (timeout_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic test_reset();
    reset_n = 1'b0; ir = IR_ADDU; moc = 1'b1; cond = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== 7'd0) $display("FAIL reset_state: got %0d, expected 0", state);
    else passed++;
    checks++;
    if (outs !== 7'h00) $display("FAIL reset_outs: got %h, expected 00", outs);
    else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    int         st [6] = '{1, 2, 3, 4, 6, 1};
    logic [6:0] ob [6] = '{7'h60, 7'h60, 7'h18, 7'h00, 7'h04, 7'h60};
    ir = IR_ADDU; moc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL alu_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL alu_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
  endtask

  // Three wait cycles without moc, moc on the fourth (the timeout cycle).
  task automatic test_load();
    int         st [10] = '{2, 3, 4, 13, 14, 14, 14, 14, 15, 1};
    logic       mv [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [6:0] ob [10] = '{7'h60, 7'h18, 7'h00, 7'h60, 7'h60, 7'h60, 7'h60, 7'h60, 7'h04, 7'h60};
    ir = IR_LW;
    for (int i = 0; i < 10; i++) begin
      moc = mv[i];
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL lw_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL lw_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
  endtask

  task automatic test_store();
    int         st [6] = '{2, 3, 4, 7, 8, 1};
    logic [6:0] ob [6] = '{7'h60, 7'h18, 7'h00, 7'h40, 7'h40, 7'h60};
    ir = IR_SW; moc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL sw_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL sw_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
  endtask

  task automatic test_branch(input logic c);
    int         st [6] = '{2, 3, 4, 11, 12, 1};
    logic [6:0] ob [6] = '{7'h60, 7'h18, 7'h00, 7'h00, 7'h00, 7'h60};
    if (c) ob[4] = 7'h08;
    ir = IR_BEQ; moc = 1'b1; cond = c;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i]))
        $display("FAIL beq%0d_state[%0d]: got %0d, expected %0d", c, i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL beq%0d_outs[%0d]: got %h, expected %h", c, i, outs, ob[i]);
      else passed++;
    end
    cond = 1'b0;
  endtask

  // Unknown opcode traps, then the flag stays set through a valid ADDU.
  task automatic test_illegal();
    int          st [10] = '{2, 3, 4, 24, 1, 2, 3, 4, 6, 1};
    logic [31:0] iv [10] = '{IR_BAD, IR_BAD, IR_BAD, IR_BAD, IR_BAD,
                             IR_ADDU, IR_ADDU, IR_ADDU, IR_ADDU, IR_ADDU};
    logic [6:0]  ob [10] = '{7'h60, 7'h18, 7'h00, 7'h02, 7'h62, 7'h62, 7'h1A, 7'h02, 7'h06, 7'h62};
    moc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ir = iv[i];
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL ill_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL ill_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
  endtask

  // moc arrives on the 4th fetch-wait cycle: no error.
  task automatic test_moc_on_limit();
    int         st [8] = '{2, 2, 2, 2, 3, 4, 6, 1};
    logic       mv [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [6:0] ob [8] = '{7'h62, 7'h62, 7'h62, 7'h62, 7'h1A, 7'h02, 7'h06, 7'h62};
    ir = IR_ADDU;
    for (int i = 0; i < 8; i++) begin
      moc = mv[i];
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL lim_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL lim_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
  endtask

  // No moc: ERROR after exactly 4 wait cycles, then held even with moc high.
  task automatic test_timeout();
    int         st [7] = '{2, 2, 2, 2, 31, 31, 31};
    logic       mv [7] = '{0, 0, 0, 0, 0, 1, 1};
    logic [6:0] ob [7] = '{7'h62, 7'h62, 7'h62, 7'h62, 7'h03, 7'h03, 7'h03};
    for (int i = 0; i < 7; i++) begin
      moc = mv[i];
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL to_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL to_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
  endtask

  // Leave ERROR by reset, then pulse reset mid store-wait.
  task automatic test_reset_mid_wait();
    int         st [7] = '{1, 2, 3, 4, 7, 8, 8};
    logic       mv [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [6:0] ob [7] = '{7'h60, 7'h60, 7'h18, 7'h00, 7'h40, 7'h40, 7'h40};
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 7'd0 || outs !== 7'h00)
      $display("FAIL err_reset: got state %0d outs %h, expected 0/00", state, outs);
    else passed++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ir = IR_SW;
    for (int i = 0; i < 7; i++) begin
      moc = mv[i];
      @(posedge clk); #1;
      checks++;
      if (state !== 7'(st[i])) $display("FAIL rst_state[%0d]: got %0d, expected %0d", i, state, st[i]);
      else passed++;
      checks++;
      if (outs !== ob[i]) $display("FAIL rst_outs[%0d]: got %h, expected %h", i, outs, ob[i]);
      else passed++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 7'd0) $display("FAIL async_state: got %0d, expected 0", state);
    else passed++;
    checks++;
    if (outs !== 7'h00) $display("FAIL async_outs: got %h, expected 00", outs);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (state !== 7'd0) $display("FAIL held_state: got %0d, expected 0", state);
    else passed++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 7'd1) $display("FAIL post_rst_state: got %0d, expected 1", state);
    else passed++;
    checks++;
    if (outs !== 7'h60) $display("FAIL post_rst_outs: got %h, expected 60", outs);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_illegal();
    test_moc_on_limit();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
